// File: rtl/bram_to_matrix_scan.sv
// Row-scanning display driver: loads one 16-column RGB row from BRAM into a line
// buffer, then shows it with 8-plane binary-code modulation, MSB plane first.

module bcm_col_lane (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_en,
  input  logic [1:0] wr_chan,
  input  logic [7:0] wr_data,
  input  logic       show,
  input  logic [2:0] plane,
  output logic       r,
  output logic       g,
  output logic       b
);
  logic [2:0][7:0] pix;
  logic [2:0][7:0] cur;

  always_ff @(posedge clk)
    if (wr_en) pix[wr_chan] <= wr_data;

  // Bypass so the byte landing on the LOAD->SHOW edge is already visible
  always_comb begin
    cur = pix;
    for (int c = 0; c < 3; c++)
      if (wr_en && wr_chan == 2'(c)) cur[c] = wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst || !show) begin
      r <= 1'b0;
      g <= 1'b0;
      b <= 1'b0;
    end else begin
      r <= cur[0][plane];
      g <= cur[1][plane];
      b <= cur[2][plane];
    end
  end
endmodule

module bram_to_matrix_scan #(
  parameter int BASE_TICKS   = 4,
  parameter int BLANK_CYCLES = 8,
  parameter int BRAM_LAT     = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic        rd_en,
  output logic [8:0]  rd_addr,
  input  logic [7:0]  rd_data,
  output logic [7:0]  row_sel,
  output logic [15:0] col_r,
  output logic [15:0] col_g,
  output logic [15:0] col_b,
  output logic        frame_start
);
  localparam int NUM_COLS = 16;
  localparam int LOAD_RDS = 48;
  localparam int LOAD_LEN = LOAD_RDS + BRAM_LAT;
  localparam int SHOW_MAX = 128 * BASE_TICKS;
  localparam int MAX_A    = (LOAD_LEN > SHOW_MAX) ? LOAD_LEN : SHOW_MAX;
  localparam int CNT_MAX  = (MAX_A > BLANK_CYCLES) ? MAX_A : BLANK_CYCLES;
  localparam int CW       = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHOW, S_BLANK} state_t;

  typedef struct packed {
    logic [3:0] col;
    logic [1:0] chan;
  } tag_t;

  state_t        state_q, state_d;
  logic [2:0]    row_q, row_d;
  logic [2:0]    plane_q, plane_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    col_q, col_d;
  logic [1:0]    chan_q, chan_d;
  logic [CW-1:0] plane_last;

  logic [BRAM_LAT-1:0] vld_pipe;
  tag_t                tag_pipe [BRAM_LAT];
  logic                cap_vld;
  tag_t                cap_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      plane_q <= 3'd7;
      cnt_q   <= '0;
      col_q   <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      plane_q <= plane_d;
      cnt_q   <= cnt_d;
      col_q   <= col_d;
      chan_q  <= chan_d;
    end
  end

  assign plane_last = (CW'(BASE_TICKS) << plane_q) - CW'(1);

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    plane_d     = plane_q;
    cnt_d       = cnt_q;
    col_d       = col_q;
    chan_d      = chan_q;
    rd_en       = 1'b0;
    frame_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        row_d   = '0;
        plane_d = 3'd7;
        cnt_d   = '0;
        col_d   = '0;
        chan_d  = '0;
        if (enable) state_d = S_LOAD;
      end
      S_LOAD: begin
        rd_en       = (cnt_q < CW'(LOAD_RDS));
        frame_start = (cnt_q == '0) && (row_q == '0);
        if (rd_en) begin
          if (chan_q == 2'd2) begin
            chan_d = '0;
            col_d  = col_q + 4'd1;
          end else begin
            chan_d = chan_q + 2'd1;
          end
        end
        // Extra BRAM_LAT cycles let the last strobe's data land before SHOW
        if (cnt_q == CW'(LOAD_LEN - 1)) begin
          state_d = S_SHOW;
          cnt_d   = '0;
          plane_d = 3'd7;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_SHOW: begin
        if (cnt_q == plane_last) begin
          cnt_d = '0;
          if (plane_q == '0) state_d = S_BLANK;
          else               plane_d = plane_q - 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_BLANK: begin
        if (cnt_q == CW'(BLANK_CYCLES - 1)) begin
          cnt_d   = '0;
          plane_d = 3'd7;
          col_d   = '0;
          chan_d  = '0;
          if (enable) begin
            state_d = S_LOAD;
            row_d   = row_q + 3'd1;
          end else begin
            state_d = S_IDLE;
            row_d   = '0;
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_addr = rd_en ? {row_q, col_q, chan_q} : 9'd0;

  // Strobe tags travel alongside the read so capture lands exactly BRAM_LAT later
  always_ff @(posedge clk) begin
    if (rst) vld_pipe <= '0;
    else begin
      for (int k = BRAM_LAT - 1; k > 0; k--) vld_pipe[k] <= vld_pipe[k-1];
      vld_pipe[0] <= rd_en;
    end
  end

  always_ff @(posedge clk) begin
    for (int k = BRAM_LAT - 1; k > 0; k--) tag_pipe[k] <= tag_pipe[k-1];
    tag_pipe[0] <= '{col: col_q, chan: chan_q};
  end

  assign cap_vld = vld_pipe[BRAM_LAT-1];
  assign cap_tag = tag_pipe[BRAM_LAT-1];

  always_ff @(posedge clk) begin
    if (rst) row_sel <= '0;
    else     row_sel <= (state_d == S_SHOW) ? (8'd1 << row_d) : 8'd0;
  end

  for (genvar n = 0; n < NUM_COLS; n++) begin : g_col
    bcm_col_lane u_lane (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cap_vld && (cap_tag.col == 4'(n))),
      .wr_chan (cap_tag.chan),
      .wr_data (rd_data),
      .show    (state_d == S_SHOW),
      .plane   (plane_d),
      .r       (col_r[n]),
      .g       (col_g[n]),
      .b       (col_b[n])
    );
  end
endmodule

// File: tb/tb_bram_to_matrix_scan.sv
// Randomized bench: driver predicts the row schedule and queues per-row expectations,
// a monitor checks load order, BCM plane windows and timing as rows are shown.

module tb_bram_to_matrix_scan;
  localparam int BT         = 4;
  localparam int BLANK      = 8;
  localparam int LAT        = 1;
  localparam int SHOW_LEN   = 255 * BT;
  localparam int ROW_PERIOD = 48 + LAT + SHOW_LEN + BLANK;

  logic        clk = 0;
  logic        rst, enable, rd_en, frame_start;
  logic [8:0]  rd_addr;
  logic [7:0]  rd_data, row_sel;
  logic [15:0] col_r, col_g, col_b;

  bram_to_matrix_scan #(.BASE_TICKS(BT), .BLANK_CYCLES(BLANK), .BRAM_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .row_sel(row_sel), .col_r(col_r), .col_g(col_g),
    .col_b(col_b), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]              row;
    logic [15:0][2:0][7:0]   pix;
  } exp_t;

  logic [7:0] mem [512];
  exp_t       expq [$];
  longint     show_starts [$];
  longint     fs_q [$];
  longint     cyc = 0;
  int         n_cmp = 0, n_bad = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'($urandom);

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic longint outs();
    return longint'({rd_en, frame_start, row_sel, col_r, col_g, col_b});
  endfunction

  function automatic int plane_of(input int o);
    int s = 0;
    for (int b = 7; b >= 0; b--) begin
      s += BT << b;
      if (o < s) return b;
    end
    return 0;
  endfunction

  function automatic exp_t snap(input int r);
    exp_t e;
    e.row = 3'(r);
    for (int c = 0; c < 16; c++)
      for (int ch = 0; ch < 3; ch++)
        e.pix[c][ch] = mem[r * 64 + c * 4 + ch];
    return e;
  endfunction

  task automatic scramble(input int r);
    for (int i = 0; i < 64; i++) mem[r * 64 + i] = 8'($urandom);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  int     addrs [$];
  longint first_rd, last_rd, show_start;
  logic   fs_first;
  logic   in_show = 0, cur_valid = 0;
  exp_t   cur;
  int     slen, bad_cyc, on_cnt, exp_on, blank_bad = 0, stray_fs = 0;
  logic [15:0] er, eg, eb;

  always @(negedge clk) begin : mon
    int errs, pl;
    if (rst) begin
      in_show = 0;
      addrs.delete();
    end else begin
      if (rd_en) begin
        if (addrs.size() == 0) begin
          first_rd = cyc;
          fs_first = frame_start;
        end else if (frame_start) stray_fs++;
        addrs.push_back(int'(rd_addr));
        last_rd = cyc;
      end else if (frame_start) stray_fs++;
      if (frame_start) fs_q.push_back(cyc);

      if (row_sel != 0) begin
        if (!in_show) begin
          in_show = 1;
          show_start = cyc;
          slen = 0; bad_cyc = 0; on_cnt = 0; exp_on = 0;
          show_starts.push_back(cyc);
          if (expq.size() == 0) begin
            cur_valid = 0;
            chk("unexpected_show", 1, 0);
          end else begin
            cur = expq.pop_front();
            cur_valid = 1;
            errs = (addrs.size() == 48) ? 0 : 100;
            for (int i = 0; i < addrs.size() && i < 48; i++)
              if (addrs[i] != int'(cur.row) * 64 + (i / 3) * 4 + (i % 3)) errs++;
            chk("load_order_errs", errs, 0);
            chk("load_strobe_span", last_rd - first_rd, 47);
            chk("load_len", cyc - first_rd, 48 + LAT);
            chk("frame_start_first_load", longint'(fs_first), longint'(cur.row == 0));
            for (int c = 0; c < 16; c++)
              for (int ch = 0; ch < 3; ch++) exp_on += int'(cur.pix[c][ch]) * BT;
          end
          addrs.delete();
        end
        if (cur_valid) begin
          pl = plane_of(slen);
          for (int n = 0; n < 16; n++) begin
            er[n] = cur.pix[n][0][pl];
            eg[n] = cur.pix[n][1][pl];
            eb[n] = cur.pix[n][2][pl];
          end
          if ({col_r, col_g, col_b} != {er, eg, eb} || row_sel != (8'd1 << cur.row))
            bad_cyc++;
        end
        on_cnt += $countones({col_r, col_g, col_b});
        slen++;
      end else begin
        if (in_show && cur_valid) begin
          chk("show_len", slen, SHOW_LEN);
          chk("show_bad_cycles", bad_cyc, 0);
          chk("show_on_cycles", on_cnt, exp_on);
        end
        in_show = 0;
        if ({col_r, col_g, col_b} != 0) blank_bad++;
      end
    end
  end

  // ---------------- driver ----------------
  initial begin
    rst = 1; enable = 0;
    for (int i = 0; i < 512; i++) mem[i] = 8'($urandom);
    for (int i = 0; i < 64; i++) mem[i] = 8'h00;
    mem[0 * 4 + 0] = 8'hA5;
    mem[3 * 4 + 1] = 8'hFF;
    mem[4 * 4 + 2] = 8'h00;
    mem[7 * 4 + 0] = 8'($urandom);

    repeat (3) begin tick(); chk("reset_outputs", outs(), 0); end
    rst = 0;
    repeat (20) begin tick(); chk("idle_outputs", outs(), 0); end

    enable = 1;
    tick();
    for (int k = 0; k < 10; k++) begin
      expq.push_back(snap(k % 8));
      repeat (200) tick();
      if (k == 9) enable = 0;
      scramble(k % 8);
      repeat (ROW_PERIOD - 200) tick();
    end
    repeat (30) begin tick(); chk("idle_after_disable", outs(), 0); end

    if (show_starts.size() >= 10) begin
      for (int k = 0; k < 9; k++)
        chk("row_period", show_starts[k+1] - show_starts[k], ROW_PERIOD);
    end else chk("show_count", show_starts.size(), 10);
    if (fs_q.size() >= 2) chk("frame_spacing", fs_q[1] - fs_q[0], 8 * ROW_PERIOD);
    else chk("frame_count", fs_q.size(), 2);

    enable = 1;
    tick();
    expq.push_back(snap(0));
    repeat (200) tick();
    rst = 1;
    tick();
    chk("rst_mid_show_outputs", outs(), 0);
    rst = 0;
    tick();
    expq.push_back(snap(0));
    repeat (200) tick();
    enable = 0;
    repeat (ROW_PERIOD - 200 + 10) tick();
    chk("idle_final", outs(), 0);
    chk("exp_queue_drained", expq.size(), 0);
    chk("cols_outside_show", blank_bad, 0);
    chk("stray_frame_start", stray_fs, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
